// File: rtl/db9_defs.sv
// Shared constants for the DB9 joystick scanner: pin and output bit
// positions, the debounce reset vector and the Mega Drive detect threshold.
package db9_defs;

  // Raw port pins, active-low: {pin9, pin6, right, left, down, up}
  localparam int PIN_UP    = 0;
  localparam int PIN_DOWN  = 1;
  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;
  localparam int PIN_6     = 4;
  localparam int PIN_9     = 5;

  // Debounced frame vector; bits [4:0] form db9joy_out
  localparam int OUT_RIGHT = 0;
  localparam int OUT_LEFT  = 1;
  localparam int OUT_DOWN  = 2;
  localparam int OUT_UP    = 3;
  localparam int OUT_FIRE  = 4;
  localparam int OUT_FIRE2 = 5;
  localparam int OUT_FIRE3 = 6;
  localparam int OUT_START = 7;

  // Every debounced bit is active-low, so all start released
  localparam logic [7:0] RESET_VEC = 8'hFF;

  // Consecutive frames needed to set or clear Mega Drive detection
  localparam int MD_DETECT_FRAMES = 2;

  // Scan phase; the encoding equals the pin-7 select level
  typedef enum logic {
    PHASE_L = 1'b0,
    PHASE_H = 1'b1
  } phase_e;

endpackage

// File: rtl/db9_debounce.sv
// One-bit frame-rate debouncer: the output follows the sample only after
// DEBOUNCE_SAMPLES consecutive differing samples, one sample per tick.
module db9_debounce #(
  parameter int   DEBOUNCE_SAMPLES = 4,
  parameter logic INIT             = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sample,
  output logic q
);

  localparam int             CW   = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_SAMPLES - 1);

  logic [CW-1:0] cnt;

  // Count differing samples; adopt the sample when the run is long enough
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      q   <= INIT;
    end else if (tick) begin
      if (sample == q) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        q   <= sample;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/db9_joystick_scanner.sv
// DB9 joystick front-end: synchronises the port pins, scans Mega Drive pads
// through the pin-7 select line, assembles one frame per H/L phase pair and
// debounces each bit at frame rate.
// Optional feature macro: DB9_MEGADRIVE_EN (select scanning, MD detection,
// A/Start buttons). Without it select is tied high and fire3_n/start_n stay 1.
module db9_joystick_scanner
  import db9_defs::*;
#(
  parameter int SCAN_DIV         = 1750,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] joy_pins,
  output logic       joy_select,
  output logic [4:0] db9joy_out,
  output logic       fire2_n,
  output logic       fire3_n,
  output logic       start_n,
  output logic       md_detected
);

  localparam int            CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [5:0]    sync1, sync2;
  logic [5:0]    h_pins;
  logic [CW-1:0] cnt;
  phase_e        phase;
  logic          end_phase, frame_tick;
  logic          a_bit, start_bit;
  logic [7:0]    frame, deb;

  // Two-flop synchroniser for the asynchronous port pins
  // NOTE: the synchroniser resets to all-released so no phantom press
  // reaches the frame logic while the pipeline refills after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 6'h3F;
      sync2 <= 6'h3F;
    end else begin
      sync1 <= joy_pins;
      sync2 <= sync1;
    end
  end

  assign end_phase  = (cnt == CNT_LAST);
  assign frame_tick = end_phase && (phase == PHASE_L);

  // Phase counter and H/L phase state; also captures the phase H sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      phase  <= PHASE_H;
      h_pins <= 6'h3F;
    end else if (end_phase) begin
      cnt <= '0;
      if (phase == PHASE_H) begin
        h_pins <= sync2;
        phase  <= PHASE_L;
      end else begin
        phase  <= PHASE_H;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef DB9_MEGADRIVE_EN
  localparam int            RW       = $clog2(MD_DETECT_FRAMES + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(MD_DETECT_FRAMES - 1);

  logic          md_frame, md_q, md_next;
  logic [RW-1:0] md_run, nomd_run;

  // An MD pad pulls left and right low while select is low
  assign md_frame = ~sync2[PIN_LEFT] & ~sync2[PIN_RIGHT];

  // Detection state for the frame being closed, usable on the same edge
  // NOTE: default assignment first keeps this block free of latches.
  always_comb begin
    md_next = md_q;
    if (md_frame && (md_run >= RUN_LAST)) begin
      md_next = 1'b1;
    end else if (!md_frame && (nomd_run >= RUN_LAST)) begin
      md_next = 1'b0;
    end
  end

  // Track consecutive MD and non-MD frames at each frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_q     <= 1'b0;
      md_run   <= '0;
      nomd_run <= '0;
    end else if (frame_tick) begin
      md_q <= md_next;
      if (md_frame) begin
        nomd_run <= '0;
        if (md_run < RUN_LAST) md_run <= md_run + 1'b1;
      end else begin
        md_run <= '0;
        if (nomd_run < RUN_LAST) nomd_run <= nomd_run + 1'b1;
      end
    end
  end

  assign a_bit       = md_next ? sync2[PIN_6] : 1'b1;
  assign start_bit   = md_next ? sync2[PIN_9] : 1'b1;
  assign joy_select  = (phase == PHASE_H);
  assign md_detected = md_q;
`else
  assign a_bit       = 1'b1;
  assign start_bit   = 1'b1;
  assign joy_select  = 1'b1;
  assign md_detected = 1'b0;
`endif

  // Frame vector: directions and B/C from phase H, A/Start from phase L
  always_comb begin
    frame            = RESET_VEC;
    frame[OUT_RIGHT] = h_pins[PIN_RIGHT];
    frame[OUT_LEFT]  = h_pins[PIN_LEFT];
    frame[OUT_DOWN]  = h_pins[PIN_DOWN];
    frame[OUT_UP]    = h_pins[PIN_UP];
    frame[OUT_FIRE]  = h_pins[PIN_6];
    frame[OUT_FIRE2] = h_pins[PIN_9];
    frame[OUT_FIRE3] = a_bit;
    frame[OUT_START] = start_bit;
  end

  for (genvar i = 0; i < 8; i++) begin : g_deb
    db9_debounce #(
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES),
      .INIT            (RESET_VEC[i])
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .tick  (frame_tick),
      .sample(frame[i]),
      .q     (deb[i])
    );
  end

  assign db9joy_out = deb[4:0];
  assign fire2_n    = deb[OUT_FIRE2];
  assign fire3_n    = deb[OUT_FIRE3];
  assign start_n    = deb[OUT_START];

endmodule

// File: tb/tb_db9_joystick_scanner.sv
// Directed bench for db9_joystick_scanner with SCAN_DIV=8, DEBOUNCE_SAMPLES=4.
// One frame is 16 cycles; after reset release, phase H ends at cycle 8+16k
// and phase L (debounce tick) at cycle 16k. Honours DB9_MEGADRIVE_EN.
module tb_db9_joystick_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] joy_pins;
  logic       joy_select;
  logic [4:0] db9joy_out;
  logic       fire2_n, fire3_n, start_n, md_detected;

  // Stimulus: Atari pins, or a Mega Drive pad model reacting to select
  logic [5:0] atari_pins;
  logic       md_attached, a_btn, c_btn, st_btn;
  logic [5:0] md_pins;

  int total = 0;
  int bad   = 0;
  int cyc;

  assign md_pins  = joy_select ? {~c_btn, 1'b1, 4'b1111}
                               : {~st_btn, ~a_btn, 1'b0, 1'b0, 1'b1, 1'b1};
  assign joy_pins = md_attached ? md_pins : atari_pins;

  db9_joystick_scanner #(
    .SCAN_DIV        (8),
    .DEBOUNCE_SAMPLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .joy_pins   (joy_pins),
    .joy_select (joy_select),
    .db9joy_out (db9joy_out),
    .fire2_n    (fire2_n),
    .fire3_n    (fire3_n),
    .start_n    (start_n),
    .md_detected(md_detected)
  );

  always #5 clk = ~clk;

  // Cycles since reset release: edge k after release gives cyc == k
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to just after edge n (counted from reset release)
  task automatic at_cycle(input int n);
    repeat (n - cyc) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Bounded wait for db9joy_out to reach exp; latency must be 49..82 cycles
  task automatic wait_out(input string tag, input logic [4:0] exp);
    int lat = 0;
    while (db9joy_out !== exp && lat < 90) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_val"}, db9joy_out, exp);
    check({tag, "_lat"}, (lat > 48 && lat <= 82), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int glitch;
    rst         = 1'b1;
    atari_pins  = 6'h3F;
    md_attached = 1'b0;
    a_btn       = 1'b0;
    c_btn       = 1'b0;
    st_btn      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    #1;
    check("rst_out",   db9joy_out,  5'b11111);
    check("rst_fire2", fire2_n,     1'b1);
    check("rst_fire3", fire3_n,     1'b1);
    check("rst_start", start_n,     1'b1);
    check("rst_md",    md_detected, 1'b0);
    check("rst_sel",   joy_select,  1'b1);
`ifdef DB9_MEGADRIVE_EN
    at_cycle(7);
    check("sel_before_fall", joy_select, 1'b1);
    at_cycle(8);
    check("sel_fall_at_8", joy_select, 1'b0);
`else
    at_cycle(8);
    check("sel_tied_high", joy_select, 1'b1);
`endif

    // Atari up press then release
    atari_pins = 6'b111110;
    wait_out("up_press", 5'b10111);
    check("up_fire2_idle", fire2_n, 1'b1);
    atari_pins = 6'b111111;
    wait_out("up_release", 5'b11111);

    // Bounce: fire low for exactly 3 frames' worth of cycles
    glitch = 0;
    atari_pins = 6'b101111;
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      if (db9joy_out[4] !== 1'b1) glitch++;
    end
    atari_pins = 6'b111111;
    for (int i = 0; i < 96; i++) begin
      @(posedge clk); #1;
      if (db9joy_out[4] !== 1'b1) glitch++;
    end
    check("bounce_fire_glitches", glitch, 0);

    // Reset mid-debounce: right held 3 frames, then reset
    atari_pins = 6'b110111;
    repeat (48) begin @(posedge clk); #1; end
    check("mid_right_pre_rst", db9joy_out[0], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_out_in_rst", db9joy_out, 5'b11111);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    at_cycle(63);
    check("mid_right_63", db9joy_out[0], 1'b1);
    at_cycle(64);
    check("mid_right_64", db9joy_out[0], 1'b0);
    atari_pins = 6'h3F;

`ifdef DB9_MEGADRIVE_EN
    // MD pad with A and C held from reset
    md_attached = 1'b1;
    a_btn       = 1'b1;
    c_btn       = 1'b1;
    st_btn      = 1'b0;
    do_reset();
    at_cycle(31);
    check("md_det_31", md_detected, 1'b0);
    at_cycle(32);
    check("md_det_32", md_detected, 1'b1);
    at_cycle(63);
    check("md_c_63", fire2_n, 1'b1);
    at_cycle(64);
    check("md_c_64", fire2_n, 1'b0);
    at_cycle(79);
    check("md_a_79", fire3_n, 1'b1);
    at_cycle(80);
    check("md_a_80",     fire3_n,    1'b0);
    check("md_start_80", start_n,    1'b1);
    check("md_dirs_80",  db9joy_out, 5'b11111);

    // Unplug: everything released
    md_attached = 1'b0;
    a_btn       = 1'b0;
    c_btn       = 1'b0;
    at_cycle(111);
    check("unplug_md_111", md_detected, 1'b1);
    at_cycle(112);
    check("unplug_md_112", md_detected, 1'b0);
    at_cycle(143);
    check("unplug_a_143", fire3_n, 1'b0);
    at_cycle(144);
    check("unplug_a_144", fire3_n, 1'b1);
    check("unplug_c_144", fire2_n, 1'b1);
`else
    // MD pad attached with A and Start held: feature must stay inert
    md_attached = 1'b1;
    a_btn       = 1'b1;
    st_btn      = 1'b1;
    c_btn       = 1'b0;
    do_reset();
    glitch = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (joy_select !== 1'b1 || md_detected !== 1'b0 ||
          fire3_n !== 1'b1 || start_n !== 1'b1) glitch++;
    end
    check("nomd_constant_outputs", glitch, 0);
    md_attached = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
